mux_4to1: RTL and testbench
===========================

Name: mux_4to1

Overview:
- 4-to-1 selector: one of four DATA_W-bit lanes packed in d is routed to y, chosen by sel.
- y is purely combinational and does not depend on the clock.
- A registered copy, y_q, is provided for downstream synchronous logic.
- Leaf datapath primitive, instantiated wherever a small static or dynamic lane select is needed.

Parameters:
- DATA_W, 1, width of each of the four input lanes and of y / y_q.
- RST_VAL, '0 (DATA_W bits), value loaded into y_q on reset.

Ports:
- clk  in  1  system clock; rising edge active.
- rst_n  in  1  synchronous reset, active-low; sampled on rising clk.
- d  in  4*DATA_W  packed lanes: lane i = d[i*DATA_W +: DATA_W]; with DATA_W=1, lane i = d[i].
- sel  in  2  lane select, 0..3.
- en  in  1  load enable for y_q.
- y  out  DATA_W  combinational selected lane.
- y_q  out  DATA_W  registered selected lane.

Behaviour:
- Interface decided: one clock (clk); reset rst_n is synchronous and active-low.
- Combinational path, zero latency:
  - y = lane[sel]: sel=00 gives lane0, 01 gives lane1, 10 gives lane2, 11 gives lane3.
  - y updates within the same delta/combinational settle as any change of d or sel.
  - y is independent of clk, rst_n and en; y is valid even with no clock toggling and while rst_n=0.
- All 4 sel encodings are legal; there is no error or invalid state.
- Simulation only: if sel contains X/Z, y shall be X (no silent default lane). No latches are allowed.
- Registered path, 1-cycle latency:
  - Rising clk with rst_n=0: y_q <= RST_VAL. Reset has priority over en.
  - Rising clk with rst_n=1 and en=1: y_q <= lane[sel] as sampled at that edge.
  - Rising clk with rst_n=1 and en=0: y_q holds.
- y_q is RST_VAL from the first reset edge until the first enabled non-reset edge.
- Reset mid-operation: y_q clears on the next rising edge with rst_n=0; y is unaffected.
- Simultaneous d/sel change with the clock edge: standard setup/hold; y_q takes the pre-edge values.
- No other state; the block has no FSM.
- Width rules:
  - d width is exactly 4*DATA_W; no truncation or extension inside the block.
  - DATA_W must be ≥1; elaboration error otherwise.

Decomposition:
- Shared package (mux_pkg):
  - SEL_W=2 and NUM_LANES=4 constants.
  - enum sel_e {SEL_L0, SEL_L1, SEL_L2, SEL_L3} for readable select encodings.
- One natural sub-module, mux_4to1_comb: the pure combinational lane select (d, sel -> y).
- Top mux_4to1 instantiates mux_4to1_comb and adds the y_q register with enable and synchronous reset.
- A parameter check (DATA_W ≥ 1) and SVA assertions live in the top:
  - y == lane[sel] whenever sel is known.
  - y_q == $past(lane[sel]) when $past(en && rst_n).
  - y_q == RST_VAL after a reset edge.

Test Plan:
- Exhaustive combinational sweep, DATA_W=1: all d 0000..1111 × sel 00..11, 5 ns per step, no clock -> y == d[sel] for all 64 combinations (e.g. d=0101, sel=10 -> y=1; sel=11 -> y=0).
- Lane isolation, DATA_W=8: d=0x44_33_22_11, sel=0,1,2,3 -> y=0x11,0x22,0x33,0x44; toggling an unselected lane never changes y.
- Reset behaviour:
  - rst_n=0 for 2 edges with en=1, d=1111, sel=00 -> y_q=0 (RST_VAL) and y=1 throughout.
  - rst_n release -> y_q=1 one edge later.
- Enable/hold: en=1 with sel=01, d=0010 -> y_q=1 after one edge; then en=0 and d=0000 -> y=0 immediately, y_q stays 1 until en returns to 1.
- Mid-operation reset: streaming en=1 with changing sel; assert rst_n=0 for one edge -> y_q=RST_VAL at that edge, resumes lane[sel] on the next enabled edge; y is never disturbed.
- X-propagation: sel=1X -> y is X in simulation; assertion checks are skipped; y_q captures X only if en=1 at that edge.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and select encodings for the 4-to-1 lane selector.
package mux_pkg;

  localparam int SEL_W     = 2;
  localparam int NUM_LANES = 4;

  // Readable names for the four select encodings.
  typedef enum logic [SEL_W-1:0] {
    SEL_L0 = 2'd0,
    SEL_L1 = 2'd1,
    SEL_L2 = 2'd2,
    SEL_L3 = 2'd3
  } sel_e;

endpackage : mux_pkg

// File: rtl/mux_4to1_comb.sv
// Pure combinational lane select: routes one of four packed lanes to y.
module mux_4to1_comb
  import mux_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic [NUM_LANES*DATA_W-1:0] d,
  input  logic [SEL_W-1:0]            sel,
  output logic [DATA_W-1:0]           y
);

  logic [DATA_W-1:0] y_s;

  // Pick the addressed lane; an unknown select produces X instead of a silent default lane.
  always_comb begin
    y_s = {DATA_W{1'b0}};
    case (sel)
      SEL_L0:  y_s = d[0*DATA_W +: DATA_W];
      SEL_L1:  y_s = d[1*DATA_W +: DATA_W];
      SEL_L2:  y_s = d[2*DATA_W +: DATA_W];
      SEL_L3:  y_s = d[3*DATA_W +: DATA_W];
      default: y_s = {DATA_W{1'bx}};
    endcase
  end

  assign y = y_s;

endmodule : mux_4to1_comb

// File: rtl/mux_4to1.sv
// 4-to-1 lane selector with a combinational output and an enabled, resettable registered copy.
module mux_4to1
  import mux_pkg::*;
#(
  parameter int                DATA_W  = 1,
  parameter logic [DATA_W-1:0] RST_VAL = {DATA_W{1'b0}}
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_LANES*DATA_W-1:0] d,
  input  logic [SEL_W-1:0]            sel,
  input  logic                        en,
  output logic [DATA_W-1:0]           y,
  output logic [DATA_W-1:0]           y_q
);

  // A zero-width lane is meaningless; stop elaboration.
  if (DATA_W < 1) begin : g_bad_width
    $error("mux_4to1: DATA_W must be at least 1");
  end

  logic [DATA_W-1:0] y_s;
  logic [DATA_W-1:0] y_q_r;

  mux_4to1_comb #(
    .DATA_W (DATA_W)
  ) u_comb (
    .d   (d),
    .sel (sel),
    .y   (y_s)
  );

  // Capture the selected lane on enabled edges; reset takes priority over enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q_r <= RST_VAL;
    end else if (en) begin
      y_q_r <= y_s;
    end else begin
      y_q_r <= y_q_r;
    end
  end

  assign y   = y_s;
  assign y_q = y_q_r;

  // Reference lane used only by the properties below.
  logic [DATA_W-1:0] lane_ref_s;
  assign lane_ref_s = d[int'(sel)*DATA_W +: DATA_W];

  a_comb_sel : assert property (@(posedge clk)
    !$isunknown(sel) |-> (y == lane_ref_s));

  a_reg_load : assert property (@(posedge clk)
    ($past(en && rst_n) && !$isunknown($past(sel))) |-> (y_q == $past(lane_ref_s)));

  a_reg_rst : assert property (@(posedge clk)
    $past(!rst_n) |-> (y_q == RST_VAL));

endmodule : mux_4to1

// File: tb/tb_mux_4to1.sv
// Self-checking bench for mux_4to1: two instances (DATA_W=1 and DATA_W=8) driven in lockstep.
module tb_mux_4to1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  sel;
  logic [3:0]  d1;
  logic [31:0] d8;
  logic        y1, y1_q;
  logic [7:0]  y8, y8_q;

  int checks = 0;
  int errors = 0;

  logic       exp_q1;
  logic [7:0] exp_q8;

  localparam logic [7:0] RST8 = 8'hA5;

  always #5 clk = ~clk;

  mux_4to1 #(.DATA_W(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .d(d1), .sel(sel), .en(en), .y(y1), .y_q(y1_q)
  );

  mux_4to1 #(.DATA_W(8), .RST_VAL(RST8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .d(d8), .sel(sel), .en(en), .y(y8), .y_q(y8_q)
  );

  // Reference: lane s of a 4-bit word is bit s.
  function automatic logic ref1(logic [3:0] d, int s);
    logic [3:0] t;
    t = d >> s;
    return t[0];
  endfunction

  // Reference: lane s of a 32-bit word is the byte s positions up.
  function automatic logic [7:0] ref8(logic [31:0] d, int s);
    logic [31:0] t;
    t = d >> (8 * s);
    return t[7:0];
  endfunction

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_y(string tag);
    chk({tag, "_y1"}, {7'd0, y1}, {7'd0, ref1(d1, int'(sel))});
    chk({tag, "_y8"}, y8, ref8(d8, int'(sel)));
  endtask

  // Advance one clock edge, updating the register model from the pre-edge inputs.
  task automatic step(string tag);
    if (!rst_n) begin
      exp_q1 = 1'b0;
      exp_q8 = RST8;
    end else if (en) begin
      exp_q1 = ref1(d1, int'(sel));
      exp_q8 = ref8(d8, int'(sel));
    end
    @(posedge clk);
    #1;
    chk({tag, "_q1"}, {7'd0, y1_q}, {7'd0, exp_q1});
    chk({tag, "_q8"}, y8_q, exp_q8);
  endtask

  initial begin
    logic [7:0] lane_exp [4];
    lane_exp[0] = 8'h11;
    lane_exp[1] = 8'h22;
    lane_exp[2] = 8'h33;
    lane_exp[3] = 8'h44;
    exp_q1 = 1'b0;
    exp_q8 = RST8;

    // Reset with enable high: registered copy held at reset value, y still live.
    rst_n = 1'b0; en = 1'b1; sel = 2'd0; d1 = 4'b1111; d8 = 32'h4433_2211;
    #1;
    check_y("rst_pre");
    chk("rst_pre_y1_one", {7'd0, y1}, 8'd1);
    step("rst_e1");
    check_y("rst_e1");
    step("rst_e2");
    chk("rst_q1_zero", {7'd0, y1_q}, 8'd0);
    chk("rst_q8_val", y8_q, 8'hA5);
    chk("rst_y1_one", {7'd0, y1}, 8'd1);

    // Release reset: first enabled edge loads the selected lane.
    rst_n = 1'b1;
    step("rel");
    chk("rel_q1_one", {7'd0, y1_q}, 8'd1);
    chk("rel_q8", y8_q, 8'h11);

    // Enable / hold.
    sel = 2'd1; d1 = 4'b0010;
    step("en_load");
    chk("en_load_q1", {7'd0, y1_q}, 8'd1);
    en = 1'b0; d1 = 4'b0000;
    #1;
    check_y("hold_y");
    chk("hold_y1_zero", {7'd0, y1}, 8'd0);
    for (int i = 0; i < 3; i++) step("hold");
    chk("hold_q1_one", {7'd0, y1_q}, 8'd1);
    en = 1'b1;
    step("en_resume");
    chk("resume_q1_zero", {7'd0, y1_q}, 8'd0);

    // Exhaustive combinational sweep with the register disabled.
    en = 1'b0;
    for (int dv = 0; dv < 16; dv++) begin
      for (int s = 0; s < 4; s++) begin
        d1  = 4'(dv);
        sel = 2'(s);
        d8  = $urandom;
        #5;
        check_y("sweep");
      end
    end
    d1 = 4'b0101; sel = 2'd2; #1;
    chk("sweep_0101_s2", {7'd0, y1}, 8'd1);
    sel = 2'd3; #1;
    chk("sweep_0101_s3", {7'd0, y1}, 8'd0);
    @(posedge clk);
    #1;
    step("sweep_hold");

    // Lane isolation on the wide instance.
    for (int s = 0; s < 4; s++) begin
      d8  = 32'h4433_2211;
      sel = 2'(s);
      #1;
      chk("iso_sel", y8, lane_exp[s]);
      for (int k = 0; k < 4; k++) begin
        if (k != s) begin
          d8[k*8 +: 8] = 8'($urandom);
          #1;
          chk("iso_toggle", y8, lane_exp[s]);
        end
      end
    end
    step("iso_hold");

    // Streaming with a one-edge reset in the middle.
    rst_n = 1'b1; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d1 = 4'($urandom); d8 = $urandom; sel = 2'(i % 4);
      rst_n = (i == 4) ? 1'b0 : 1'b1;
      #1;
      check_y("midrst");
      step("midrst");
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 200; i++) begin
      d1    = 4'($urandom);
      d8    = $urandom;
      sel   = 2'($urandom_range(0, 3));
      en    = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 9) != 0);
      #1;
      check_y("rand");
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mux_4to1
